cpu_clock_ctrl: RTL and testbench
=================================

# cpu_clock_ctrl

Clock-enable and reset sequencer for `cpu_core`. It divides the 12 MHz board clock into a single-cycle CPU clock-enable, holds the CPU in reset for a parametrised number of CPU cycles, and adds run, halt and single-step modes. It also counts executed CPU cycles. The block sits between the board clock/reset pins and `cpu_core`, and the `cpu_core` bench uses it to replace its fixed reset delay.

## Interface
Parameters:
- `CLK_DIV`, default 12: `i_Clk` cycles per CPU cycle (12 MHz gives 1 MHz). Legal range is ≥ 2.
- `RESET_CYCLES`, default 10: number of CPU enables issued while CPU reset is held low. Legal range is ≥ 1.
- `CNT_W`, default 32: width of the executed-cycle counter.

Ports:
- `i_Clk`, in, 1: system clock. Single clock domain.
- `i_Rst_L`, in, 1: reset. Synchronous and active-low.
- `i_Halt`, in, 1: level input. Requests halt while high.
- `i_Step`, in, 1: single-cycle pulse. Requests one CPU cycle while halted. The input is already synchronised and debounced.
- `o_Cpu_En`, out, 1: CPU clock-enable. High for exactly one `i_Clk` cycle per CPU cycle.
- `o_Cpu_Rst_L`, out, 1: CPU reset, active-low, registered.
- `o_Phi2`, out, 1: phase indicator for bus timing and debug. High while divider count ≥ `CLK_DIV/2`.
- `o_Halted`, out, 1: high in the HALTED state.
- `o_Cycle_Count`, out, `CNT_W`: number of enables issued with `o_Cpu_Rst_L` high. Wraps modulo 2^`CNT_W`.

## Operation
- **Divider**
  - Counter `div` counts 0..`CLK_DIV`-1 and wraps. It runs in every state.
  - `tick` = (`div` == `CLK_DIV`-1).
  - `o_Cpu_En` is registered. It goes high on the edge where `tick` is true and the current state allows an enable.
- **States:** RESET_HOLD, RUN, HALTED. All decisions are taken only on tick edges.
- **RESET_HOLD**
  - Every tick issues an enable and increments `rst_cnt`.
  - On the tick where `rst_cnt` == `RESET_CYCLES`:
    - `o_Cpu_Rst_L` goes to 1.
    - If `i_Halt` is 0: go to RUN, and this tick issues an enable that is counted.
    - If `i_Halt` is 1: go to HALTED with no enable.
  - `i_Step` is ignored in this state.
- **RUN**
  - Every tick issues an enable and increments `o_Cycle_Count`.
  - If `i_Halt` is 1 on a tick: go to HALTED, and that tick issues no enable.
  - `i_Step` is ignored.
- **HALTED**
  - An `i_Step` pulse sets `step_pend`. Further pulses before the next tick do not accumulate.
  - On a tick:
    - If `i_Halt` is 0: go to RUN and issue an enable. `step_pend` is cleared.
    - Otherwise, if `step_pend` is set: issue one enable, increment the count, clear `step_pend`, and stay in HALTED.
    - Otherwise: no enable.
  - If `i_Step` arrives on the tick cycle itself, it counts as pending for that tick.
- **Reset (`i_Rst_L` sampled low)**
  - At any time, including mid-cycle or while halted, the next edge forces: `div`=0, `rst_cnt`=0, state RESET_HOLD, `step_pend`=0.
  - Output reset values on that edge: `o_Cpu_En`=0, `o_Cpu_Rst_L`=0, `o_Phi2`=0, `o_Halted`=0, `o_Cycle_Count`=0.

## Timing
- Edges are numbered from the first edge with `i_Rst_L` sampled high, starting at 1.
  - `div` equals n mod `CLK_DIV`.
  - `o_Cpu_En` is high in the cycle after edges k·`CLK_DIV`.
- The first enable follows edge `CLK_DIV`.
- `o_Cpu_Rst_L` rises at edge (`RESET_CYCLES`+1)·`CLK_DIV`. With the defaults this is edge 132.
- Enable spacing is exactly `CLK_DIV` cycles, with no jitter in any mode.
- A halt request takes effect at the first tick where `i_Halt` is sampled high. There is no latency beyond that tick.
- A step executes at the next tick after the pulse, so latency is 1 to `CLK_DIV` cycles.
- `o_Cycle_Count` and `o_Halted` update on the same edge as the corresponding `o_Cpu_En` or state change.

## Structure
- Shared header `cpu_clk_defs.vh`:
  - State encoding localparams (RESET_HOLD=2'd0, RUN=2'd1, HALTED=2'd2).
  - Default `CLK_DIV` and `RESET_CYCLES` for the board.
- Sub-module `clk_divider`:
  - Modulo-`CLK_DIV` counter with `tick` and `phase` outputs.
  - Synchronous active-low reset.
  - Reused later by the UART and VGA blocks.
- Top-level `cpu_clock_ctrl` holds the FSM, the `rst_cnt` counter (width $clog2(`RESET_CYCLES`+1)), `step_pend` and the cycle counter.

## Test plan
All scenarios use `CLK_DIV`=4 and `RESET_CYCLES`=3.
- **Power-on:** release `i_Rst_L` with `i_Halt`=0.
  - Enables follow edges 4, 8 and 12 with `o_Cpu_Rst_L`=0.
  - At edge 16: `o_Cpu_Rst_L`=1, `o_Cpu_En`=1, count=1.
  - At edge 40: count=7.
- **Halt in RUN:** raise `i_Halt` before edge 24.
  - No enable at edge 24 or later.
  - `o_Halted`=1 from edge 24.
  - Count frozen at 2.
- **Single-step:** while halted, pulse `i_Step` three times in one divider period, then once more later.
  - Exactly one enable per tick that has a pending step, so 2 enables in total.
  - Count increases by 2.
- **Halt held through reset exit:** hold `i_Halt`=1 across reset exit.
  - `o_Cpu_Rst_L` rises at edge 16 with no enable.
  - Drop `i_Halt`: RUN resumes at the next tick with an enable.
- **Reset mid-operation:** assert `i_Rst_L`=0 for one cycle during RUN with `div`=2.
  - Next edge: all outputs at reset values, count=0.
  - The sequence then repeats the power-on timing.
- **Counter wrap:** with `CNT_W`=4, run 20 enables.
  - `o_Cycle_Count`=4 after the wrap.

Source files
------------

// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable / reset sequencer and its divider.
package cpu_clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        HALTED     = 2'd2
    } state_e;

    // 12 MHz board clock down to a 1 MHz CPU, ten CPU cycles of reset.
    localparam int DEF_CLK_DIV      = 12;
    localparam int DEF_RESET_CYCLES = 10;

endpackage

// File: rtl/cpu_clock_ctrl_clk_divider.sv
// Modulo-CLK_DIV counter producing a terminal-count tick and a half-period phase flag.
module clk_divider
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    output logic o_Tick,
    output logic o_Phase
);

    localparam int              DW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]   HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = o_Tick ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) div_q <= '0;
        else          div_q <= div_d;
    end

    assign o_Tick  = (div_q == LAST);
    assign o_Phase = (div_q >= HALF);

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable and reset sequencer: reset hold, run, halt and single-step
// modes on top of a fixed divider, plus an executed-cycle counter.
module cpu_clock_ctrl
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int CNT_W        = 32
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Halt,
    input  logic             i_Step,
    output logic             o_Cpu_En,
    output logic             o_Cpu_Rst_L,
    output logic             o_Phi2,
    output logic             o_Halted,
    output logic [CNT_W-1:0] o_Cycle_Count
);

    localparam int            RW       = $clog2(RESET_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES);

    logic tick;

    state_e           state_q, state_d;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic             step_pend_q, step_pend_d;
    logic             en_q, en_d;
    logic             cpu_rst_l_q, cpu_rst_l_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .o_Tick  (tick),
        .o_Phase (o_Phi2)
    );

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        step_pend_d = step_pend_q;
        en_d        = 1'b0;
        cpu_rst_l_d = cpu_rst_l_q;
        cnt_d       = cnt_q;

        // A step landing on the tick cycle itself is served by that tick.
        if (tick) step_pend_d = 1'b0;
        else if (state_q == HALTED && i_Step) step_pend_d = 1'b1;

        if (tick) begin
            unique case (state_q)
                RESET_HOLD: begin
                    if (rst_cnt_q == RST_LAST) begin
                        cpu_rst_l_d = 1'b1;
                        if (i_Halt) begin
                            state_d = HALTED;
                        end else begin
                            state_d = RUN;
                            en_d    = 1'b1;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        en_d      = 1'b1;
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                RUN: begin
                    if (i_Halt) begin
                        state_d = HALTED;
                    end else begin
                        en_d  = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HALTED: begin
                    if (!i_Halt) begin
                        state_d = RUN;
                        en_d    = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (step_pend_q || i_Step) begin
                        en_d  = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = RESET_HOLD;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q     <= RESET_HOLD;
            rst_cnt_q   <= '0;
            step_pend_q <= 1'b0;
            en_q        <= 1'b0;
            cpu_rst_l_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            step_pend_q <= step_pend_d;
            en_q        <= en_d;
            cpu_rst_l_q <= cpu_rst_l_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_Cpu_En      = en_q;
    assign o_Cpu_Rst_L   = cpu_rst_l_q;
    assign o_Halted      = (state_q == HALTED);
    assign o_Cycle_Count = cnt_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with CLK_DIV=4, RESET_CYCLES=3; a second
// instance with a 4-bit counter covers the wrap case.
module tb_cpu_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0, halt = 1'b0, step = 1'b0;
    logic       en, crst, hlt, phi;
    logic [7:0] cnt;
    logic       w_en, w_crst, w_hlt, w_phi;
    logic [3:0] w_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_clock_ctrl #(.CLK_DIV(4), .RESET_CYCLES(3), .CNT_W(8)) dut (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Halt(halt), .i_Step(step),
        .o_Cpu_En(en), .o_Cpu_Rst_L(crst), .o_Phi2(phi), .o_Halted(hlt),
        .o_Cycle_Count(cnt)
    );

    cpu_clock_ctrl #(.CLK_DIV(4), .RESET_CYCLES(3), .CNT_W(4)) dut_w (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Halt(halt), .i_Step(step),
        .o_Cpu_En(w_en), .o_Cpu_Rst_L(w_crst), .o_Phi2(w_phi), .o_Halted(w_hlt),
        .o_Cycle_Count(w_cnt)
    );

    typedef struct {
        logic r, h, s;
        int   adv;
        logic en, crst, hlt, phi;
        int   cnt;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic r, logic h, logic s, int adv,
                                logic e, logic cr, logic hl, logic ph, int c);
        vec_t v;
        v.r = r; v.h = h; v.s = s; v.adv = adv;
        v.en = e; v.crst = cr; v.hlt = hl; v.phi = ph; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e, input logic cr,
                           input logic hl, input logic ph, input int c);
        chk({tag, ".en"},    32'(en),   32'(e));
        chk({tag, ".rst"},   32'(crst), 32'(cr));
        chk({tag, ".halt"},  32'(hlt),  32'(hl));
        chk({tag, ".phi2"},  32'(phi),  32'(ph));
        chk({tag, ".cnt"},   32'(cnt),  32'(c[7:0]));
        chk({tag, ".w_en"},  32'(w_en), 32'(e));
        chk({tag, ".w_cnt"}, 32'(w_cnt), 32'(c[3:0]));
    endtask

    task automatic cyc(input logic r, input logic h, input logic s);
        rst_l = r; halt = h; step = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_en;

        // r h s adv | en crst hlt phi cnt   (edge numbers after the entry)
        tbl[0]  = mk(0, 0, 0,  1, 0, 0, 0, 0, 0);  // reset edge
        tbl[1]  = mk(1, 0, 0,  2, 0, 0, 0, 1, 0);  // e2
        tbl[2]  = mk(1, 0, 0,  1, 0, 0, 0, 1, 0);  // e3
        tbl[3]  = mk(1, 0, 0,  1, 1, 0, 0, 0, 0);  // e4 first enable
        tbl[4]  = mk(1, 0, 0,  1, 0, 0, 0, 0, 0);  // e5
        tbl[5]  = mk(1, 0, 0,  3, 1, 0, 0, 0, 0);  // e8
        tbl[6]  = mk(1, 0, 0,  4, 1, 0, 0, 0, 0);  // e12
        tbl[7]  = mk(1, 0, 0,  3, 0, 0, 0, 1, 0);  // e15
        tbl[8]  = mk(1, 0, 0,  1, 1, 1, 0, 0, 1);  // e16 reset released
        tbl[9]  = mk(1, 0, 0,  4, 1, 1, 0, 0, 2);  // e20
        tbl[10] = mk(1, 0, 0, 20, 1, 1, 0, 0, 7);  // e40
        tbl[11] = mk(1, 0, 0,  2, 0, 1, 0, 1, 7);  // e42, div=2
        tbl[12] = mk(0, 0, 0,  1, 0, 0, 0, 0, 0);  // reset mid-run
        tbl[13] = mk(1, 0, 0,  4, 1, 0, 0, 0, 0);  // e4 again
        tbl[14] = mk(1, 0, 0, 12, 1, 1, 0, 0, 1);  // e16
        tbl[15] = mk(1, 0, 0,  4, 1, 1, 0, 0, 2);  // e20
        tbl[16] = mk(1, 1, 0,  3, 0, 1, 0, 1, 2);  // e23, halt raised
        tbl[17] = mk(1, 1, 0,  1, 0, 1, 1, 0, 2);  // e24 halted, no enable
        tbl[18] = mk(1, 1, 0,  4, 0, 1, 1, 0, 2);  // e28 frozen

        cyc(0, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 19; i++) begin
            for (int k = 0; k < tbl[i].adv; k++) cyc(tbl[i].r, tbl[i].h, tbl[i].s);
            chk_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].crst, tbl[i].hlt,
                    tbl[i].phi, tbl[i].cnt);
        end

        // Single-step: three pulses in one period give one enable, then one more.
        n_en = 0;
        cyc(1, 1, 1); n_en += int'(en);   // e29
        cyc(1, 1, 0); n_en += int'(en);   // e30
        cyc(1, 1, 1); n_en += int'(en);   // e31
        cyc(1, 1, 1); n_en += int'(en);   // e32 tick
        chk_all("step_e32", 1, 1, 1, 0, 3);
        cyc(1, 1, 0); n_en += int'(en);   // e33
        cyc(1, 1, 1); n_en += int'(en);   // e34
        cyc(1, 1, 0); n_en += int'(en);   // e35
        cyc(1, 1, 0); n_en += int'(en);   // e36 tick
        chk_all("step_e36", 1, 1, 1, 0, 4);
        for (int k = 0; k < 4; k++) begin cyc(1, 1, 0); n_en += int'(en); end
        chk("step_enables", 32'(n_en), 32'd2);
        chk_all("step_e40", 0, 1, 1, 0, 4);
        // Step pulse arriving exactly on the tick cycle.
        cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
        cyc(1, 1, 1);                      // e44
        chk_all("step_on_tick", 1, 1, 1, 0, 5);

        // Reset while halted, then halt held across reset exit.
        cyc(0, 1, 0);
        chk_all("rst_halted", 0, 0, 0, 0, 0);
        n_en = 0;
        for (int k = 0; k < 15; k++) begin cyc(1, 1, 0); n_en += int'(en); end
        chk("hold_enables", 32'(n_en), 32'd3);
        cyc(1, 1, 0);                      // e16
        chk_all("hold_exit", 0, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) cyc(1, 1, 0);
        chk_all("hold_e20", 0, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0);
        chk_all("resume_e24", 1, 1, 0, 0, 1);

        // Counter wrap on the 4-bit instance: 20 counted enables.
        cyc(0, 0, 0);
        for (int k = 0; k < 76; k++) cyc(1, 0, 0);
        chk("wrap_e76", 32'(w_cnt), 32'd0);
        chk("cnt_e76", 32'(cnt), 32'd16);
        for (int k = 0; k < 16; k++) cyc(1, 0, 0);
        chk_all("wrap_e92", 1, 1, 0, 0, 20);
        chk("wrap_rst", 32'(w_crst), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
